// File: rtl/hh_gate_scheduler_if.sv
// Request/acknowledge link between the gate scheduler and the shared
// gating-rate datapath.
interface hh_gate_scheduler_if #(
    parameter int unsigned W = 16
);
    logic         dp_req;
    logic [1:0]   dp_sel;
    logic [W-1:0] dp_v;
    logic [W-1:0] dp_g;
    logic         dp_ack;
    logic [W-1:0] dp_g_next;

    modport master (
        output dp_req, dp_sel, dp_v, dp_g,
        input  dp_ack, dp_g_next
    );

    modport slave (
        input  dp_req, dp_sel, dp_v, dp_g,
        output dp_ack, dp_g_next
    );
endinterface

// File: rtl/hh_gate_scheduler.sv
// Time-multiplexes one Hodgkin-Huxley gating-rate datapath across m, h and n
// for each integration step and commits the three new gate values atomically.
module hh_gate_scheduler #(
    parameter int unsigned  W       = 16,
    parameter logic [W-1:0] M_INIT  = 16'h0355,
    parameter logic [W-1:0] H_INIT  = 16'h4CCD,
    parameter logic [W-1:0] N_INIT  = 16'h0A3D,
    parameter int unsigned  TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [W-1:0]        i_v_in,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [W-1:0]        o_m_out,
    output logic [W-1:0]        o_h_out,
    output logic [W-1:0]        o_n_out,
    hh_gate_scheduler_if.master dp
);
    localparam logic [W-1:0]  ONE      = {1'b1, {(W-1){1'b0}}};
    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_req;
    logic [W-1:0]  r_v;
    logic [W-1:0]  r_sh_m;
    logic [W-1:0]  r_sh_h;
    logic [W-1:0]  w_g_sel;

    // Gates are Q1.15 probabilities; anything above 1.0 saturates to 1.0.
    function automatic logic [W-1:0] clamp(input logic [W-1:0] g);
        return (g > ONE) ? ONE : g;
    endfunction

    always_comb begin
        w_g_sel = o_m_out;
        case (r_idx)
            2'd1:    w_g_sel = o_h_out;
            2'd2:    w_g_sel = o_n_out;
            default: w_g_sel = o_m_out;
        endcase
    end

    assign dp.dp_req = r_req;
    assign dp.dp_sel = r_idx;
    assign dp.dp_v   = r_v;
    assign dp.dp_g   = w_g_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_req   <= 1'b0;
            r_v     <= '0;
            r_sh_m  <= '0;
            r_sh_h  <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_m_out <= M_INIT;
            o_h_out <= H_INIT;
            o_n_out <= N_INIT;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_v     <= i_v_in;
                        o_err   <= 1'b0;
                        r_idx   <= '0;
                        r_tmo   <= '0;
                        r_req   <= 1'b1;
                        o_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dp.dp_ack) begin
                        r_req <= 1'b0;
                        r_tmo <= '0;
                        if (r_idx == 2'd0) r_sh_m <= dp.dp_g_next;
                        if (r_idx == 2'd1) r_sh_h <= dp.dp_g_next;
                        // n is committed straight from the bus with the two shadows.
                        if (r_idx == 2'd2) begin
                            o_m_out <= clamp(r_sh_m);
                            o_h_out <= clamp(r_sh_h);
                            o_n_out <= clamp(dp.dp_g_next);
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_req   <= 1'b0;
                        o_err   <= 1'b1;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_GAP: begin
                    r_idx   <= r_idx + 1'b1;
                    r_tmo   <= '0;
                    r_req   <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/hh_gate_scheduler.md
# hh_gate_scheduler

Sequences one shared Hodgkin–Huxley gating-update datapath across the three gate variables m, h and n for each integration step. The datapath computes g_next from (V, g). This block time-multiplexes that datapath through a req/ack handshake, holds the architectural m/h/n state and commits all three results atomically. It sits between the neuron step controller (start/done) and the single gating-rate unit.

## Interface
Parameters:
- W, 16, data width of V and gate values. Gates are unsigned Q1.15, so 1.0 = 0x8000.
- M_INIT, 16'h0355, reset value of m.
- H_INIT, 16'h4CCD, reset value of h.
- N_INIT, 16'h0A3D, reset value of n.
- TIMEOUT, 64, maximum consecutive cycles dp_req may wait for dp_ack.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one integration step. Accepted only in IDLE.
- v_in  in  W  membrane potential. Sampled on the accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at the end of every step, including an aborted step.
- err  out  1  set on timeout. Cleared on the next accepted start.
- m_out, h_out, n_out  out  W each  committed gate values.
- dp_req  out  1  datapath request.
- dp_sel  out  2  gate being computed: 0 = m, 1 = h, 2 = n.
- dp_v  out  W  latched V.
- dp_g  out  W  committed (old) value of the selected gate.
- dp_ack  in  1  one-cycle pulse; dp_g_next is valid in that cycle.
- dp_g_next  in  W  datapath result.

## Operation
- States: IDLE, WAIT, GAP, DONE. A 2-bit gate index idx runs 0→2. A timeout counter counts WAIT cycles.
- IDLE:
  - start=1 → latch v_in, clear err, idx=0, enter WAIT.
  - start while busy is ignored; it is not queued.
- WAIT:
  - dp_req=1; dp_sel=idx; dp_v and dp_g are stable.
  - dp_ack=1 → store dp_g_next into shadow[idx].
    - idx<2 → enter GAP.
    - idx=2 → commit, enter DONE.
  - No ack for TIMEOUT consecutive WAIT cycles → set err, discard all shadows, enter DONE without commit.
- GAP:
  - dp_req=0 for exactly one cycle. idx++ and the timeout counter clears.
  - Return to WAIT.
- DONE: done=1 for one cycle, then IDLE. start in the DONE cycle is ignored.
- Commit:
  - m/h/n update together on the edge that samples the final ack.
  - All three datapath calls within a step use the pre-step m/h/n and the same V. There is no intra-step feedback.
- Clamp on commit: values with bit15=1 and bits14:0≠0 (above 0x8000) are written as 0x8000. All other values are written unchanged.
- dp_ack outside WAIT is ignored and has no side effects.
- dp_sel and dp_g are don't-care when dp_req=0. They are driven to the idx value and are never X.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, err=0, dp_req=0, dp_sel=0, dp_v=0.
  - m_out=M_INIT, h_out=H_INIT, n_out=N_INIT.
- Reset mid-step aborts immediately: no commit, no done pulse, outputs return to reset values.
- Cycle numbering: start is sampled at edge 0.
  - WAIT(m) occupies cycle 1 onward.
  - With ack in the first WAIT cycle of each gate: WAIT m=1, GAP=2, WAIT h=3, GAP=4, WAIT n=5, DONE=6.
  - New m_out/h_out/n_out are visible in cycle 6, together with done.
- Minimum step latency is 6 cycles from the start edge to the done cycle. Each ack delay of k cycles adds k.
- Timeout: with no ack, the cycle after the TIMEOUT-th WAIT cycle is DONE with err=1.
- dp_req falls in the cycle after the ack cycle. The datapath must not ack twice per request.

## Test plan
- Basic step:
  - Stimulus: reset; start with v_in=0xFF9C. Datapath model returns g+0x0010 with immediate ack.
  - Required: done at cycle 6; m_out=0x0365, h_out=0x4CDD, n_out=0x0A4D; dp_sel sequence 0,1,2; each dp_g equals the pre-step value.
- Variable latency:
  - Stimulus: ack delays of 0, 3 and 7 cycles.
  - Required: done at cycle 16; dp_v, dp_sel and dp_g stable throughout each WAIT; outputs unchanged until the commit.
- Clamp:
  - Stimulus: datapath returns 0x8001 for h and 0xFFFF for n.
  - Required: h_out=0x8000, n_out=0x8000; m_out is written unclamped.
- Timeout:
  - Stimulus: TIMEOUT=64; no ack on the h request.
  - Required: done with err=1 at cycle 3+64; m/h/n keep their pre-step values. The next start clears err.
- Ignored events:
  - Stimulus: start pulses in cycles 2 and 6; a stray dp_ack in IDLE and in GAP.
  - Required: exactly one step runs and no shadow or state changes from the stray acks.
- Reset mid-step:
  - Stimulus: assert rst asynchronously in cycle 4.
  - Required: dp_req=0, busy=0 immediately; outputs equal M_INIT/H_INIT/N_INIT; no done pulse.
